// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a FIFO read port and serialises each byte as a UART frame.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional even parity, stop bit.
// Ports:
//   clk, reset       - clock; synchronous active-high reset
//   fifo_rd_val      - FIFO non-empty
//   fifo_rd_en       - pop request (combinational; only asserted in IDLE)
//   fifo_rd_data     - FIFO read data, valid the cycle after a pop edge
//   tx               - registered serial line, idle high
//   busy             - high whenever the FSM is not in IDLE
//   frames_sent      - count of completed frames, wraps at 16 bits
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_rd_val,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  tx,
    output logic                  busy,
    output logic [15:0]           frames_sent
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int NW = $clog2(DATA_WIDTH) + 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [NW-1:0] BIT_LAST  = NW'(DATA_WIDTH - 1);
    localparam logic [NW-1:0] BIT_ONE   = NW'(1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [BW-1:0]           baud_q, baud_d;
    logic [NW-1:0]           bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_q, par_d;
    logic                    tx_q, tx_d;
    logic [15:0]             frames_q, frames_d;
    logic                    baud_tc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            frames_q <= frames_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tx_d     = tx_q;
        frames_d = frames_q;
        baud_tc  = (baud_q == BAUD_LAST);

        // Reset gates the pop so the FIFO keeps its word.
        fifo_rd_en = !reset && (state_q == IDLE) && fifo_rd_val;

        // Bit-period counter only runs while a line bit is on the wire.
        if (state_q != IDLE && state_q != FETCH) begin
            baud_d = baud_tc ? '0 : baud_q + BAUD_ONE;
        end

        unique case (state_q)
            IDLE: begin
                if (fifo_rd_en) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                shift_d = fifo_rd_data;
                par_d   = ^fifo_rd_data;
                tx_d    = 1'b0;
                baud_d  = '0;
                state_d = START;
            end
            START: begin
                if (baud_tc) begin
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_tc) begin
                    if (bit_q < BIT_LAST) begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                        bit_d   = bit_q + BIT_ONE;
                    end else if (PARITY_EN) begin
                        tx_d    = par_q;
                        state_d = PARITY;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end
                end
            end
            PARITY: begin
                if (baud_tc) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (baud_tc) begin
                    frames_d = frames_q + 16'd1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tx          = tx_q;
    assign busy        = (state_q != IDLE);
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx with a FIFO model and a
// per-cycle line scoreboard; one instance without parity, one with parity.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        val0 = 1'b0;
    logic        val1 = 1'b0;
    logic [7:0]  rdata0 = 8'h00;
    logic [7:0]  rdata1 = 8'h00;
    logic        en0, en1, tx0, tx1, busy0, busy1;
    logic [15:0] fs0, fs1;

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .fifo_rd_val(val0), .fifo_rd_en(en0),
        .fifo_rd_data(rdata0), .tx(tx0), .busy(busy0), .frames_sent(fs0)
    );

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .fifo_rd_val(val1), .fifo_rd_en(en1),
        .fifo_rd_data(rdata1), .tx(tx1), .busy(busy1), .frames_sent(fs1)
    );

    logic [7:0]  fq0[$];
    logic [7:0]  fq1[$];
    logic        sb0[$];
    logic        sb1[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] expf0 = 16'h0;
    logic [15:0] expf1 = 16'h0;
    int          sel = 0;

    logic        m_en, m_tx, m_busy;
    logic [15:0] m_fs;
    assign m_en   = (sel == 1) ? en1 : en0;
    assign m_tx   = (sel == 1) ? tx1 : tx0;
    assign m_busy = (sel == 1) ? busy1 : busy0;
    assign m_fs   = (sel == 1) ? fs1 : fs0;

    // FIFO model: pop on rd_en edge, data valid the following cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (en0) rdata0 <= fq0.pop_front();
        val0 <= (fq0.size() != 0);
        if (en1) rdata1 <= fq1.pop_front();
        val1 <= (fq1.size() != 0);
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic sb_pop(input int s);
        if (s == 1) return sb1.pop_front();
        return sb0.pop_front();
    endfunction

    // Push a word into the FIFO and its expected per-cycle line levels.
    task automatic load(input int s, input logic [7:0] d);
        int   nb;
        logic b;
        nb = (s == 1) ? 11 : 10;
        for (int i = 0; i < nb; i++) begin
            if (i == 0) b = 1'b0;
            else if (i <= 8) b = d[i-1];
            else if (s == 1 && i == 9) b = ^d;
            else b = 1'b1;
            repeat (CPB) begin
                if (s == 1) sb1.push_back(b);
                else sb0.push_back(b);
            end
        end
        if (s == 1) fq1.push_back(d);
        else fq0.push_back(d);
    endtask

    task automatic run_frame(input int s, input int ncheck, output int pop_cyc);
        int n;
        int len;
        sel = s;
        len = (s == 1) ? 11 * CPB : 10 * CPB;
        #1;
        n = 0;
        while (m_en !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        pop_cyc = cyc;
        chk("pop_req", 16'(m_en), 16'h1);
        if (m_en !== 1'b1) return;
        chk("idle_busy", 16'(m_busy), 16'h0);
        @(negedge clk);
        chk("fetch_tx", 16'(m_tx), 16'h1);
        chk("fetch_busy", 16'(m_busy), 16'h1);
        chk("fetch_en", 16'(m_en), 16'h0);
        for (int i = 0; i < ncheck; i++) begin
            @(negedge clk);
            chk("line_tx", 16'(m_tx), 16'(sb_pop(s)));
            chk("line_busy", 16'(m_busy), 16'h1);
            chk("line_en", 16'(m_en), 16'h0);
        end
        if (ncheck == len) begin
            @(negedge clk);
            chk("end_busy", 16'(m_busy), 16'h0);
            if (s == 1) expf1 = expf1 + 16'd1;
            else expf0 = expf0 + 16'd1;
            chk("frames", m_fs, (s == 1) ? expf1 : expf0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        expf0 = 16'h0;
        expf1 = 16'h0;
    endtask

    initial begin
        int pc;
        int prev;

        // Reset with a word waiting: no pop while reset is high.
        reset = 1'b1;
        load(0, 8'hA5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_en", 16'(en0), 16'h0);
            chk("rst_tx", 16'(tx0), 16'h1);
            chk("rst_busy", 16'(busy0), 16'h0);
            chk("rst_frames", fs0, 16'h0);
            chk("rst_tx_p", 16'(tx1), 16'h1);
            chk("rst_busy_p", 16'(busy1), 16'h0);
        end
        reset = 1'b0;

        // Single 0xA5 frame, the word kept through reset.
        run_frame(0, 10 * CPB, pc);

        // Even parity: 0x07 -> 1, 0x03 -> 0.
        do_reset();
        load(1, 8'h07);
        run_frame(1, 11 * CPB, pc);
        load(1, 8'h03);
        run_frame(1, 11 * CPB, pc);

        // Back-to-back frames, 42-cycle period.
        do_reset();
        load(0, 8'h00);
        load(0, 8'hFF);
        load(0, 8'h3C);
        run_frame(0, 10 * CPB, prev);
        run_frame(0, 10 * CPB, pc);
        chk("b2b_gap1", 16'(pc - prev), 16'd42);
        prev = pc;
        run_frame(0, 10 * CPB, pc);
        chk("b2b_gap2", 16'(pc - prev), 16'd42);
        chk("b2b_empty", 16'(fq0.size()), 16'h0);
        chk("b2b_val", 16'(val0), 16'h0);
        chk("b2b_frames", fs0, 16'd3);

        // Reset during data bit 3 of 0x55; 0x96 follows intact.
        do_reset();
        load(0, 8'h55);
        load(0, 8'h96);
        run_frame(0, 4 * CPB + 2, pc);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_tx", 16'(tx0), 16'h1);
        chk("mid_busy", 16'(busy0), 16'h0);
        chk("mid_en", 16'(en0), 16'h0);
        chk("mid_frames", fs0, 16'h0);
        repeat (10 * CPB - (4 * CPB + 2)) void'(sb_pop(0));
        reset = 1'b0;
        run_frame(0, 10 * CPB, pc);

        // Counter wrap.
        do_reset();
        force dut0.frames_q = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        release dut0.frames_q;
        @(negedge clk);
        chk("wrap_pre", fs0, 16'hFFFF);
        expf0 = 16'hFFFF;
        load(0, 8'h81);
        run_frame(0, 10 * CPB, pc);
        chk("wrap_post", fs0, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for the team's `fifo` block. It pops bytes from the FIFO read port and serialises each one onto a UART-style line:

- 1 start bit, DATA_WIDTH data bits LSB first, optional even parity, 1 stop bit.
- Each bit lasts CLKS_PER_BIT clocks.

It connects directly to the FIFO's `rd_en`/`rd_val`/`rd_data` port and owns all read timing on that port.

## Interface
- DATA_WIDTH, 8, width of `fifo_rd_data` and of each serialised word
- CLKS_PER_BIT, 16, clocks per line bit; legal range ≥ 2
- PARITY_EN, 0, 1 = append even-parity bit after the data bits
- clk  input  1  clock; all logic is on the rising edge
- reset  input  1  reset, synchronous, active-high
- fifo_rd_val  input  1  FIFO non-empty
- fifo_rd_en  output  1  pop request to FIFO
- fifo_rd_data  input  DATA_WIDTH  FIFO read data; valid in the cycle after a pop edge
- tx  output  1  serial line, idle high
- busy  output  1  high in every state except IDLE
- frames_sent  output  16  count of completed frames; wraps 0xFFFF -> 0x0000

## Operation
- **States:** IDLE, FETCH, START, DATA, PARITY, STOP.
- **Reset values:** tx=1, busy=0, fifo_rd_en=0, frames_sent=0, state=IDLE, bit and baud counters=0.
- **Pop request:** `fifo_rd_en = (state==IDLE) & fifo_rd_val`.
  - Combinational; forced 0 while reset=1.
  - Never asserted outside IDLE, so at most one pop per frame.
- **IDLE -> FETCH:** on an edge where fifo_rd_en=1. The FIFO pops on the same edge.
- **FETCH (1 cycle):**
  - Shift register <= fifo_rd_data.
  - Parity bit <= XOR of fifo_rd_data.
  - tx <= 0, state -> START, baud counter <= 0.
- **Baud counter:** counts 0..CLKS_PER_BIT-1. The terminal count (CLKS_PER_BIT-1) ends the current bit.
- **START:** at terminal count:
  - tx <= shift[0], state -> DATA, bit counter <= 0.
- **DATA:** at terminal count:
  - If bit counter < DATA_WIDTH-1: shift right, tx <= next LSB, bit counter +1.
  - Else: go to PARITY (tx <= parity) if PARITY_EN, otherwise go to STOP (tx <= 1).
- **PARITY:** at terminal count, tx <= 1, state -> STOP.
- **STOP:** at terminal count:
  - state -> IDLE, frames_sent +1.
  - tx stays 1.
- **Widths:**
  - Baud counter is $clog2(CLKS_PER_BIT) bits.
  - Bit counter is $clog2(DATA_WIDTH)+1 bits.
  - No other arithmetic.
- **Input sampling:**
  - fifo_rd_data is sampled only in FETCH.
  - Changes on fifo_rd_val or fifo_rd_data during START through STOP are ignored.
- **Reset mid-frame:**
  - All state returns to reset values on the next edge and tx returns to 1.
  - The frame in flight is lost (it was already popped) and is not counted.
- **Reset in the same cycle as a would-be pop:** fifo_rd_en=0, so the FIFO keeps the word.

## Timing
- **Latency:** pop edge E -> FETCH cycle -> tx falls at edge E+1. Latency from fifo_rd_en high to start-bit edge is 2 clocks.
- **Bit timing:** every line bit, including stop, is exactly CLKS_PER_BIT cycles. A frame is (2+DATA_WIDTH+PARITY_EN)*CLKS_PER_BIT cycles.
- **Back-to-back frames:** after STOP, one IDLE cycle (pop) plus one FETCH cycle with tx=1. Period = frame length + 2 cycles.
- **busy:**
  - Rises at the pop edge (FETCH is busy).
  - Falls at the edge entering IDLE.
  - frames_sent increments on that same edge.
- **Empty FIFO:** block idles with tx=1 indefinitely. A pop occurs in the first IDLE cycle with fifo_rd_val=1.
- **Glitch-free output:** tx is a register output.

## Test plan
- **Reset values:** hold reset 3 cycles with fifo_rd_val=1 -> fifo_rd_en=0 throughout; tx=1, busy=0, frames_sent=0.
- **Single frame (CLKS_PER_BIT=4, PARITY_EN=0):** FIFO holds 0xA5 -> fifo_rd_en is high for exactly 1 cycle.
  - tx runs 0,1,0,1,0,0,1,0,1,1 at 4 cycles each, starting 2 cycles after the pop.
  - frames_sent=1 after 40 cycles; busy is high for 41 cycles.
- **Parity (PARITY_EN=1, CLKS_PER_BIT=4):** send 0x07 -> parity bit 1; send 0x03 -> parity bit 0. Frame is 44 cycles.
- **Back-to-back:** preload 0x00, 0xFF, 0x3C -> three frames, each start bit 42 cycles after the previous one (CLKS_PER_BIT=4). The FIFO ends empty and frames_sent=3.
- **Reset mid-data:** assert reset during bit 3 of 0x55 -> tx=1 and busy=0 on the next edge; frames_sent is unchanged. The next FIFO word is transmitted intact after reset drops.
- **Counter wrap:** force frames_sent to 0xFFFF and send 1 frame -> frames_sent=0x0000.
